burst_send_ctrl: RTL

Parametrised successor to the single-burst send controller in the median-filter output path. It queues burst requests and emits `send_buff_size` pixel writes per burst under FIFO backpressure. Alongside the pixels it writes N_CTRL side-band control FIFOs atomically, on either the first or the last pixel of each burst. It sits between the median-sort core (request/size source) and the output pixel/control FIFOs.

---
 rtl/burst_send_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/burst_send_ctrl.sv
// burst_send_ctrl: queues burst requests and streams send_buff_size pixel
// writes per burst into the pixel FIFO under backpressure, writing all
// N_CTRL side-band control FIFOs atomically on the first or last pixel.
module burst_send_ctrl #(
    parameter int BUFF_SIZE     = 32,
    parameter int BUFF_SIZE_BIT = $clog2(BUFF_SIZE) + 1,
    parameter int N_CTRL        = 4,
    parameter int MAX_PENDING   = 4,
    parameter int PEND_BIT      = $clog2(MAX_PENDING + 1),
    parameter int CTRL_AT_LAST  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_next,
    input  logic [BUFF_SIZE_BIT-1:0] send_buff_size,
    input  logic                     send_px_full,
    input  logic [N_CTRL-1:0]        send_ctrl_full,
    output logic                     send_px_wr,
    output logic [N_CTRL-1:0]        send_ctrl_wr,
    output logic                     sending,
    output logic [BUFF_SIZE_BIT-1:0] px_send_count,
    output logic                     send_done,
    output logic [PEND_BIT-1:0]      pending,
    output logic                     req_drop
);

    localparam logic [BUFF_SIZE_BIT-1:0] SIZE_LIM = BUFF_SIZE_BIT'(BUFF_SIZE);
    localparam logic [PEND_BIT-1:0]      PEND_MAX = PEND_BIT'(MAX_PENDING);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                    state_q;
    logic [BUFF_SIZE_BIT-1:0]  count_q;
    logic [BUFF_SIZE_BIT-1:0]  size_q;
    logic [PEND_BIT-1:0]       pending_q;

    logic [PEND_BIT-1:0]       pending_d;
    logic [BUFF_SIZE_BIT-1:0]  size_clamped;
    logic [BUFF_SIZE_BIT-1:0]  last_idx;
    logic                      in_send;
    logic                      ctrl_beat;
    logic                      beat;
    logic                      last_beat;
    logic                      empty_burst;
    logic                      done;
    logic                      drop;
    logic                      accept;

    // Beat qualification, completion and request-queue bookkeeping
    always_comb begin
        size_clamped = (send_buff_size > SIZE_LIM) ? SIZE_LIM : send_buff_size;
        last_idx     = size_q - BUFF_SIZE_BIT'(1);
        in_send      = (state_q == SEND);
        ctrl_beat    = (CTRL_AT_LAST != 0) ? (count_q == last_idx) : (count_q == '0);
        // A blocked control channel stalls the ctrl beat's pixel too.
        beat         = in_send & ~send_px_full & (~ctrl_beat | ~|send_ctrl_full);
        last_beat    = beat & (count_q == last_idx);
        empty_burst  = (state_q == IDLE) & (pending_q != '0) & (send_buff_size == '0);
        done         = last_beat | empty_burst;
        drop         = up_next & (pending_q == PEND_MAX) & ~done;
        accept       = up_next & ~drop;
        pending_d    = pending_q;
        if (accept && !done) begin
            pending_d = pending_q + PEND_BIT'(1);
        end else if (!accept && done) begin
            pending_d = pending_q - PEND_BIT'(1);
        end
    end

    // Burst FSM with pixel index, sampled burst length and request queue depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            size_q    <= '0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (pending_q != '0 && send_buff_size != '0) begin
                        size_q  <= size_clamped;
                        count_q <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (last_beat) begin
                        count_q <= '0;
                        // Chain straight into the next queued burst when possible.
                        if (pending_d != '0 && send_buff_size != '0) begin
                            size_q  <= size_clamped;
                            state_q <= SEND;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (beat) begin
                        count_q <= count_q + BUFF_SIZE_BIT'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        send_px_wr    = beat;
        send_ctrl_wr  = {N_CTRL{beat & ctrl_beat}};
        sending       = in_send;
        px_send_count = count_q;
        send_done     = done;
        pending       = pending_q;
        req_drop      = drop;
    end

endmodule
